id_ex_stage: RTL and testbench

- Pipeline register between the decode stage (opcode control decoder, register file read, immediate generator) and the execute stage.
- Latches the decoded control bundle and operands for EX.
- Detects load-use hazards and stalls decode, inserting a bubble.
- Honours a branch flush from later stages and backpressure from a multicycle EX unit (mul/div/vector).

---
 rtl/id_ex_stage.sv | 97 +++++++++
 tb/tb_id_ex_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush, EX backpressure and stall counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_stall,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = 15 + 4 * XLEN + 4;
  logic             valid_q, valid_d;
  logic [7:0]       ctrl_q, ctrl_d, id_ctrl;
  logic [DW-1:0]    data_q, data_d, id_data;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  assign id_ctrl = {id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_aluop};
  assign id_data = {id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc, id_funct3, id_funct7b5};
  assign {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop} = ctrl_q;
  assign {ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_funct3, ex_funct7b5} = data_q;
  assign ex_valid  = valid_q;
  assign stall_cnt = cnt_q;
  // both sources compared even when the consumer ignores rs2 (conservative)
  assign load_use = valid_q & ex_memread & (|ex_rd) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign id_stall = !flush & (load_use | !ex_ready);
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (ex_ready) begin
      if (load_use) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        data_d  = '0;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        valid_d = id_valid;
        ctrl_d  = id_valid ? id_ctrl : '0;
        data_d  = id_data;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a rule-level model.
module tb_id_ex_stage;
  typedef struct packed {
    logic        v;
    logic [7:0]  c;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [2:0]  f3;
    logic        f7;
  } bun_t;
  localparam logic [7:0] LW  = 8'b0110_1100;
  localparam logic [7:0] ADD = 8'b0000_0110;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ex_ready = 1'b1;
  bun_t in = '0, got, m = '0, snap;
  logic [3:0] mcnt = '0, stall_cnt;
  logic id_stall;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(in.v),
    .id_branch(in.c[7]), .id_memread(in.c[6]), .id_memtoreg(in.c[5]), .id_memwrite(in.c[4]),
    .id_alusrc(in.c[3]), .id_regwrite(in.c[2]), .id_aluop(in.c[1:0]),
    .id_rs1(in.rs1), .id_rs2(in.rs2), .id_rd(in.rd),
    .id_rs1_data(in.d1), .id_rs2_data(in.d2), .id_imm(in.imm), .id_pc(in.pc),
    .id_funct3(in.f3), .id_funct7b5(in.f7), .flush(flush), .ex_ready(ex_ready),
    .id_stall(id_stall), .ex_valid(got.v),
    .ex_branch(got.c[7]), .ex_memread(got.c[6]), .ex_memtoreg(got.c[5]), .ex_memwrite(got.c[4]),
    .ex_alusrc(got.c[3]), .ex_regwrite(got.c[2]), .ex_aluop(got.c[1:0]),
    .ex_rs1(got.rs1), .ex_rs2(got.rs2), .ex_rd(got.rd),
    .ex_rs1_data(got.d1), .ex_rs2_data(got.d2), .ex_imm(got.imm), .ex_pc(got.pc),
    .ex_funct3(got.f3), .ex_funct7b5(got.f7), .stall_cnt(stall_cnt)
  );
  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic hazard();
    return m.v && m.c[6] && m.rd != 0 && in.v && (m.rd == in.rs1 || m.rd == in.rs2);
  endfunction
  function automatic bun_t ins(input logic [7:0] c, input logic [4:0] rs1, rs2, rd, input logic [31:0] imm);
    bun_t b;
    b = '{v: 1'b1, c: c, rs1: rs1, rs2: rs2, rd: rd, d1: $urandom, d2: $urandom, imm: imm,
          pc: $urandom & 32'hffff_fffc, f3: 3'($urandom), f7: 1'($urandom)};
    return b;
  endfunction
  // one clock: check the combinational stall, clock, advance the model, check EX
  task automatic cyc(input bun_t b, input logic fl, input logic rdy);
    in = b; flush = fl; ex_ready = rdy;
    #1;
    check("id_stall", 160'(id_stall), 160'(!fl && (hazard() || !rdy)));
    @(posedge clk);
    if (fl) m = '0;
    else if (rdy && hazard()) begin
      m = '0;
      mcnt = (mcnt == 4'd15) ? mcnt : mcnt + 4'd1;
    end else if (rdy) begin
      m = b;
      if (!b.v) m.c = '0;
    end
    #1;
    check("ex_bundle", 160'(got), 160'(m));
    check("stall_cnt", 160'(stall_cnt), 160'(mcnt));
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_ex", 160'(got), 160'(0));
    check("reset_cnt", 160'(stall_cnt), 160'(0));
    m = '0; mcnt = '0;
    @(negedge clk) rst_n = 1'b1;
  endtask
  initial begin
    bun_t b;
    #1;
    check("por_ex", 160'(got), 160'(0));
    check("por_cnt", 160'(stall_cnt), 160'(0));
    @(negedge clk) rst_n = 1'b1;
    cyc(ins(ADD, 5'd1, 5'd2, 5'd5, 32'd0), 1'b0, 1'b1);
    check("add_in_ex", 160'({got.v, got.c, got.rd}), 160'({1'b1, ADD, 5'd5}));
    async_reset();
    b = ins(LW, 5'd2, 5'd0, 5'd5, 32'd8);
    cyc(b, 1'b0, 1'b1);
    check("lw_pass", 160'(got), 160'(b));
    in = ins(ADD, 5'd5, 5'd7, 5'd6, 32'd0);
    #1 check("lu_stall", 160'(id_stall), 160'(1));
    b = in;
    cyc(b, 1'b0, 1'b1);
    check("lu_bubble", 160'({got.v, got.c}), 160'(0));
    cyc(b, 1'b0, 1'b1);
    check("lu_add", 160'({got.v, got.rd, stall_cnt}), 160'({1'b1, 5'd6, 4'd1}));
    cyc(ins(LW, 5'd1, 5'd1, 5'd0, 32'd4), 1'b0, 1'b1);
    cyc(ins(ADD, 5'd0, 5'd0, 5'd9, 32'd0), 1'b0, 1'b1);
    check("x0_no_bubble", 160'({got.v, got.rd}), 160'({1'b1, 5'd9}));
    cyc(ins(LW, 5'd1, 5'd1, 5'd5, 32'd4), 1'b0, 1'b1);
    cyc(ins(ADD, 5'd5, 5'd3, 5'd6, 32'd0), 1'b1, 1'b1);
    check("flush_kill", 160'({got.v, got.c, stall_cnt}), 160'({9'd0, 4'd1}));
    cyc(ins(ADD, 5'd3, 5'd4, 5'd10, 32'd0), 1'b0, 1'b1);
    snap = got;
    for (int i = 0; i < 3; i++) begin
      cyc(ins(ADD, 5'd10, 5'd1, 5'd11, 32'd0), 1'b0, 1'b0);
      check("hold", 160'(got), 160'(snap));
    end
    b = ins(ADD, 5'd10, 5'd1, 5'd11, 32'd0);
    cyc(b, 1'b0, 1'b1);
    check("after_hold", 160'(got), 160'(b));
    b = ins(LW, 5'd3, 5'd3, 5'd0, 32'd0);
    b.v = 1'b0;
    cyc(b, 1'b0, 1'b1);
    check("invalid_sanitised", 160'({got.v, got.c}), 160'(0));
    async_reset();
    b = ins(LW, 5'd5, 5'd1, 5'd5, 32'd0);
    for (int i = 0; i < 41; i++) cyc(b, 1'b0, 1'b1);
    check("saturate", 160'(stall_cnt), 160'(15));
    async_reset();
    for (int i = 0; i < 600; i++) begin
      b = ins(8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom);
      b.v = ($urandom_range(0, 99) < 85);
      cyc(b, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 80));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
